paritygen_8bit: RTL and testbench
=================================

PARITYGEN_8BIT -- requirements
Module: paritygen_8bit

Interface
REQ-001 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 = even-parity bit and 1 = odd-parity bit.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port d, input, 8 bits: data word to be covered by the parity bit.
REQ-005 The block SHALL have port v, input, 1 bit: supply/valid qualifier; 0 = generator unpowered, output forced low.
REQ-006 The block SHALL have port en, input, 1 bit: evaluate enable; 1 = compute a new parity bit, 0 = hold.
REQ-007 The block SHALL have port pb, output, 1 bit: registered parity bit.
REQ-008 One clock; reset asynchronous and active-low; no other clock or reset inputs SHALL exist.

Function
REQ-009 d, v and en SHALL be sampled only at the rising edge of clk; changes between edges SHALL have no effect on pb.
REQ-010 Even mode (PARITY_ODD=0): on a rising edge with v=1 and en=1, pb SHALL become the XOR of d[7:0]. The XOR SHALL be 1 when d has an odd number of ones, so that d plus pb holds an even count.
REQ-011 Odd mode (PARITY_ODD=1): on a rising edge with v=1 and en=1, pb SHALL become the inverted XOR of d[7:0].
REQ-012 On a rising edge with v=1 and en=0, pb SHALL hold its previous value.
REQ-013 On a rising edge with v=0, pb SHALL become 0 regardless of en and d. The v=0 rule takes priority over en.
REQ-014 Latency SHALL be exactly one clk cycle from sampled inputs to pb. The block SHALL accept a new evaluation every cycle with no handshake or stall.
REQ-015 The output pb SHALL be driven directly from a flip-flop, with no combinational path from d, v or en to pb.
REQ-016 All 256 values of d SHALL be supported, including boundaries:
- 8'h00: pb=0 in even mode.
- 8'hFF: pb=0 in even mode.
- any single-bit word: pb=1 in even mode.
REQ-017 Unknown (X/Z) inputs are outside scope. The block SHALL NOT contain latches, tristates or pull-up structures; it is purely synthesizable logic.

Reset
REQ-018 rst_n=0 SHALL immediately force pb to 0, independent of clk.
REQ-019 pb SHALL stay 0 while rst_n is low.
REQ-020 After rst_n deasserts, the first update SHALL occur at the next rising clk edge, following REQ-010 to REQ-013.
REQ-021 Reset asserted mid-operation SHALL discard the held parity value. There is no other internal state.

Verification
REQ-022 Reset: assert rst_n=0 between edges with pb=1 -> pb=0 immediately, and it stays 0 until the first edge after release.
REQ-023 Even mode, v=1, en=1: d=8'h4B -> pb=0 after one edge; d=8'h01 -> pb=1; d=8'hFF -> pb=0; d=8'h00 -> pb=0; d=8'h80 -> pb=1.
REQ-024 Hold: compute pb=1 with d=8'h07, then set en=0 and d=8'h03 -> pb stays 1 for all following edges until en=1.
REQ-025 Supply off: pb=1, then set v=0 with en either 0 or 1 and any d -> pb=0 on the next edge. Then v=1, en=1, d=8'h0B -> pb=1.
REQ-026 Odd mode (PARITY_ODD=1), v=1, en=1: d=8'h4B -> pb=1; d=8'h01 -> pb=0.
REQ-027 Exhaustive and random run: all 256 values of d with random v/en toggling each cycle -> pb matches a reference model of REQ-010 to REQ-013 every cycle.

Source files
------------

// File: rtl/paritygen_8bit.sv
// Purpose: registered even/odd parity bit over an 8-bit data word, gated by a supply/valid qualifier.
// Latency: one clk cycle from sampled d/v/en to pb; a new word is accepted every cycle.
// Backpressure: none; en=0 holds the last parity bit, v=0 forces pb low.
//
// Ports:
//   clk   - single clock, all state updates on its rising edge
//   rst_n - asynchronous active-low reset, clears pb
//   d     - 8-bit data word covered by the parity bit
//   v     - supply/valid qualifier; 0 forces pb to 0 (overrides en)
//   en    - evaluate enable; 1 computes a new parity bit, 0 holds
//   pb    - parity bit, driven straight from a flip-flop
module paritygen_8bit #(
   parameter bit PARITY_ODD = 1'b0   // 0 = even parity, 1 = odd parity
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] d,
   input  logic       v,
   input  logic       en,
   output logic       pb
);

   logic par_next;

   // XOR-reduce gives even parity; folding in PARITY_ODD inverts it for odd mode.
   always_comb begin
      par_next = (^d) ^ PARITY_ODD;
   end

   // v=0 is checked before en so an unpowered generator always reads 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pb <= 1'b0;
      end else if (!v) begin
         pb <= 1'b0;
      end else if (en) begin
         pb <= par_next;
      end
   end

endmodule

// File: tb/tb_paritygen_8bit.sv
module tb_paritygen_8bit;

   logic       clk;
   logic       rst_n;
   logic [7:0] d;
   logic       v;
   logic       en;
   logic       pb_e;
   logic       pb_o;

   int checks;
   int failures;

   bit q_e[$];
   bit q_o[$];
   bit last_e;
   bit last_o;

   typedef struct {
      logic [7:0] d;
      logic       v;
      logic       en;
      logic       exp_e;
      logic       exp_o;
   } vec_t;

   vec_t tbl[16];

   paritygen_8bit #(.PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst_n(rst_n), .d(d), .v(v), .en(en), .pb(pb_e)
   );

   paritygen_8bit #(.PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .d(d), .v(v), .en(en), .pb(pb_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got pb=%b expected pb=%b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive one word, queue the expected results, then compare just after the edge.
   task automatic step(input logic [7:0] dd, input logic vv, input logic ee,
                       input logic exp_e, input logic exp_o, input string name);
      bit ee_q;
      bit eo_q;
      d  = dd;
      v  = vv;
      en = ee;
      q_e.push_back(exp_e);
      q_o.push_back(exp_o);
      last_e = exp_e;
      last_o = exp_o;
      @(posedge clk);
      #1;
      ee_q = q_e.pop_front();
      eo_q = q_o.pop_front();
      check({name, "_even"}, pb_e, ee_q);
      check({name, "_odd"},  pb_o, eo_q);
      #2;
   endtask

   initial begin
      bit m_e;
      bit m_o;
      logic [7:0] rd;
      logic rv;
      logic ren;

      checks   = 0;
      failures = 0;

      tbl[0]  = '{8'h4B, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{8'h0B, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{8'h4B, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[15] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset state
      rst_n = 1'b0;
      d     = 8'h00;
      v     = 1'b0;
      en    = 1'b0;
      #3;
      check("reset_even", pb_e, 1'b0);
      check("reset_odd",  pb_o, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #2;

      // Directed table
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].d, tbl[i].v, tbl[i].en, tbl[i].exp_e, tbl[i].exp_o,
              $sformatf("tbl%0d", i));
      end

      // Inputs changing between edges must not reach pb
      d  = 8'h00;
      v  = 1'b0;
      en = 1'b1;
      #2;
      check("between_edges_even", pb_e, 1'b1);
      check("between_edges_odd",  pb_o, 1'b0);

      // Asynchronous reset mid-cycle while pb_e=1
      step(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, "pre_reset");
      rst_n = 1'b0;
      #1;
      check("reset_immediate_even", pb_e, 1'b0);
      @(posedge clk);
      #1;
      check("reset_held_even", pb_e, 1'b0);
      check("reset_held_odd",  pb_o, 1'b0);
      #2;
      rst_n = 1'b1;
      #1;
      check("reset_release_even", pb_e, 1'b0);
      #1;
      step(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, "post_reset");

      // Every single-bit word gives even parity 1
      for (int b = 0; b < 8; b++) begin
         rd = 8'h01 << b;
         step(rd, 1'b1, 1'b1, 1'b1, 1'b0, $sformatf("onehot%0d", b));
      end

      // Exhaustive d with random v/en against a reference model
      m_e = last_e;
      m_o = last_o;
      for (int i = 0; i < 256; i++) begin
         rd  = i[7:0];
         rv  = 1'($urandom_range(0, 3) != 0);
         ren = 1'($urandom_range(0, 1));
         if (!rv) begin
            m_e = 1'b0;
            m_o = 1'b0;
         end else if (ren) begin
            m_e = ^rd;
            m_o = ~(^rd);
         end
         step(rd, rv, ren, m_e, m_o, $sformatf("rand_d%02h", rd));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
